// File: rtl/secded137_pkg.sv
// Shared layout definition for the 137-bit SEC-DED code (128 data + 8 Hamming + 1 overall parity).
// The encoder and decoder both derive their bit placement from the functions here.
package secded137_pkg;

   localparam int DATA_W = 128;
   localparam int CODE_W = 137;
   localparam int CHK_W  = 8;

   // A codeword position holds a Hamming check bit when it is a power of two.
   function automatic logic is_check_pos(input int pos);
      return (pos > 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Data bit idx sits at the idx-th non-power-of-two position above 0.
   function automatic int data_pos(input int idx);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int q = 1; q < CODE_W; q++) begin
         if (!is_check_pos(q)) begin
            if (cnt == idx) pos = q;
            cnt++;
         end
      end
      return pos;
   endfunction

   // Positions 1..CODE_W-1 whose index has bit b set; syndrome bit b is the XOR over this mask.
   function automatic logic [CODE_W-1:0] syn_mask(input int b);
      logic [CODE_W-1:0] m;
      m = '0;
      for (int q = 1; q < CODE_W; q++) begin
         m[q] = ((q >> b) & 1) != 0;
      end
      return m;
   endfunction

endpackage

// File: rtl/secded137_syndrome.sv
// Combinational syndrome / overall-parity generator, shared by the decoder and scrubbing logic.
module secded137_syndrome
   import secded137_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [CHK_W-1:0]  syndrome,
   output logic              parity
);

   // Each syndrome bit is the XOR of the codeword bits whose position index has that bit set,
   // which equals the XOR of the indices of all set bits.
   for (genvar gi = 0; gi < CHK_W; gi++) begin : g_syn
      localparam logic [CODE_W-1:0] MASK = syn_mask(gi);
      assign syndrome[gi] = ^(code & MASK);
   end

   assign parity = ^code;

endmodule

// File: rtl/secded137_decoder.sv
// Two-stage valid/ready SEC-DED decoder for the 137-bit code with saturating error counters.
// Stage 1 captures the data field, syndrome and overall parity; stage 2 corrects and classifies.
module secded137_decoder
   import secded137_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sec,
   output logic              out_ded,
   output logic [CHK_W-1:0]  out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  sec_cnt,
   output logic [CNT_W-1:0]  ded_cnt
);

   localparam logic [CHK_W-1:0] MAX_POS = CHK_W'(CODE_W - 1);

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic [CHK_W-1:0]  s1_syn;
   logic              s1_par;

   logic [CHK_W-1:0]  syn_comb;
   logic              par_comb;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] fix_data;
   logic              sec_comb;
   logic              ded_comb;

   logic              s2_ready;
   logic              in_fire;
   logic              s1_fire;
   logic              out_fire;

   secded137_syndrome u_syndrome (
      .code     (in_code),
      .syndrome (syn_comb),
      .parity   (par_comb)
   );

   assign s2_ready = !out_valid || out_ready;
   assign in_ready = !s1_valid || s2_ready;
   assign in_fire  = in_valid && in_ready;
   assign s1_fire  = s1_valid && s2_ready;
   assign out_fire = out_valid && out_ready;

   // Only the data field travels down the pipe; a flipped check bit never changes the data,
   // so the check bits are consumed entirely by the syndrome generator.
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam int POS = data_pos(gi);
      assign in_data[gi]  = in_code[POS];
      assign fix_data[gi] = s1_data[gi] ^ (sec_comb && (s1_syn == CHK_W'(POS)));
   end

   // Classify the registered syndrome/parity pair; sec and ded are mutually exclusive.
   always_comb begin
      sec_comb = s1_par && (s1_syn <= MAX_POS);
      ded_comb = s1_par ? (s1_syn > MAX_POS) : (s1_syn != '0);
   end

   // Stage 1: capture data field, syndrome and parity on input handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_data  <= in_data;
         s1_syn   <= syn_comb;
         s1_par   <= par_comb;
      end else if (s1_fire) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: register corrected data and flags; fields hold while the output is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_sec      <= 1'b0;
         out_ded      <= 1'b0;
         out_syndrome <= '0;
      end else if (s1_fire) begin
         out_valid    <= 1'b1;
         out_data     <= fix_data;
         out_sec      <= sec_comb;
         out_ded      <= ded_comb;
         out_syndrome <= s1_syn;
      end else if (out_fire) begin
         out_valid    <= 1'b0;
      end
   end

   // Saturating statistics, counted on delivery; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sec_cnt <= '0;
         ded_cnt <= '0;
      end else if (cnt_clr) begin
         sec_cnt <= '0;
         ded_cnt <= '0;
      end else if (out_fire) begin
         if (out_sec && (sec_cnt != '1)) sec_cnt <= sec_cnt + CNT_W'(1);
         if (out_ded && (ded_cnt != '1)) ded_cnt <= ded_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_secded137_decoder.sv
// Self-checking bench for secded137_decoder: directed cases plus randomized traffic checked
// against an independent arithmetic model of the code.
module tb_secded137_decoder;

   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [136:0]     in_code;
   logic             out_valid;
   logic             out_ready;
   logic [127:0]     out_data;
   logic             out_sec;
   logic             out_ded;
   logic [7:0]       out_syndrome;
   logic             cnt_clr;
   logic [CNT_W-1:0] sec_cnt;
   logic [CNT_W-1:0] ded_cnt;

   secded137_decoder #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_sec      (out_sec),
      .out_ded      (out_ded),
      .out_syndrome (out_syndrome),
      .cnt_clr      (cnt_clr),
      .sec_cnt      (sec_cnt),
      .ded_cnt      (ded_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] data;
      logic         sec;
      logic         ded;
      logic [7:0]   syn;
   } exp_t;

   exp_t exp_q[$];
   int   pos_of[128];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_sec    = 0;
   int   m_ded    = 0;
   bit   last_acc = 0;

   function automatic bit is_pow2(input int p);
      return (p > 0) && ((p & (p - 1)) == 0);
   endfunction

   function automatic logic [7:0] syn_of(input logic [136:0] c);
      logic [7:0] s;
      s = 8'd0;
      for (int p = 1; p < 137; p++) if (c[p]) s = s ^ p[7:0];
      return s;
   endfunction

   // Place data, then choose check bits so the syndrome is zero, then set even overall parity.
   function automatic logic [136:0] encode(input logic [127:0] d);
      logic [136:0] c;
      logic [7:0]   s;
      c = '0;
      for (int k = 0; k < 128; k++) c[pos_of[k]] = d[k];
      s = syn_of(c);
      for (int j = 0; j < 8; j++) c[1 << j] = s[j];
      c[0] = ^c;
      return c;
   endfunction

   function automatic exp_t model(input logic [136:0] c);
      exp_t         r;
      logic [7:0]   s;
      logic [136:0] fx;
      s = syn_of(c);
      fx = c;
      r.syn = s;
      r.sec = 1'b0;
      r.ded = 1'b0;
      if (^c) begin
         if (s <= 8'd136) begin
            r.sec = 1'b1;
            fx[s] = ~fx[s];
         end else begin
            r.ded = 1'b1;
         end
      end else if (s != 8'd0) begin
         r.ded = 1'b1;
      end
      for (int k = 0; k < 128; k++) r.data[k] = fx[pos_of[k]];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: compare outputs/counters with the model at the falling edge, record handshakes,
   // then return 1 time unit after the next rising edge for the caller to drive inputs.
   task automatic step();
      exp_t e;
      last_acc = 0;
      @(negedge clk);
      chk("sec_cnt", sec_cnt, m_sec);
      chk("ded_cnt", ded_cnt, m_ded);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", out_valid, 1'b0);
         end else begin
            e = exp_q[0];
            chk("out_data", out_data, e.data);
            chk("out_sec", out_sec, e.sec);
            chk("out_ded", out_ded, e.ded);
            chk("out_syndrome", out_syndrome, e.syn);
            if (out_ready) begin
               void'(exp_q.pop_front());
               if (!cnt_clr) begin
                  if (e.sec && m_sec < CMAX) m_sec++;
                  if (e.ded && m_ded < CMAX) m_ded++;
               end
            end
         end
      end
      if (cnt_clr) begin
         m_sec = 0;
         m_ded = 0;
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(in_code));
         last_acc = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [136:0] c);
      bit ok;
      ok = 0;
      in_code  = c;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_acc) begin
            ok = 1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_out(input string tag);
      for (int i = 0; i < 10; i++) begin
         if (out_valid) break;
         step();
      end
      if (!out_valid) chk(tag, 1'b0, 1'b1);
   endtask

   task automatic send_check(input string tag, input logic [136:0] c,
                             input logic [7:0] syn, input logic sec, input logic ded);
      send(c);
      wait_out({tag, "_timeout"});
      chk({tag, "_syn"}, out_syndrome, syn);
      chk({tag, "_sec"}, out_sec, sec);
      chk({tag, "_ded"}, out_ded, ded);
      step();
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         step();
      end
      chk(tag, exp_q.size(), 0);
   endtask

   function automatic logic [136:0] rand_code();
      logic [136:0] c;
      logic [159:0] w;
      int           b1;
      int           b2;
      c  = encode({$urandom, $urandom, $urandom, $urandom});
      b1 = $urandom_range(136, 0);
      b2 = (b1 + 1 + $urandom_range(135, 0)) % 137;
      case ($urandom % 5)
         0: ;
         1: c[b1] = ~c[b1];
         2: begin c[b1] = ~c[b1]; c[b2] = ~c[b2]; end
         3: begin
            c[b1] = ~c[b1];
            c[b2] = ~c[b2];
            c[(b2 + 1 + $urandom_range(134, 0)) % 137] ^= 1'b1;
         end
         default: begin
            w = {$urandom, $urandom, $urandom, $urandom, $urandom};
            c = w[136:0];
         end
      endcase
      return c;
   endfunction

   initial begin
      logic [136:0] c;
      logic [136:0] w[4];
      int           idx;
      int           p;

      p = 2;
      for (int k = 0; k < 128; k++) begin
         do p++; while (is_pow2(p));
         pos_of[k] = p;
      end

      // Reset state
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_code   = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_sec_cnt", sec_cnt, 0);
      chk("rst_ded_cnt", ded_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b1);

      // All-zero codeword with 2-cycle latency
      in_code  = '0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_cycle1_valid", out_valid, 1'b0);
      step();
      chk("lat_cycle2_valid", out_valid, 1'b1);
      chk("zero_data", out_data, 128'd0);
      chk("zero_syn", out_syndrome, 8'd0);
      step();

      // 10 encoded words back-to-back at full rate
      for (int i = 0; i < 10; i++) begin
         in_code  = encode({$urandom, $urandom, $urandom, $urandom});
         in_valid = 1'b1;
         step();
         chk("b2b_accept", last_acc, 1'b1);
      end
      in_valid = 1'b0;
      step();
      step();
      chk("b2b_throughput", exp_q.size(), 0);

      // Directed single and multiple error cases
      c = '0; c[3] = 1'b1;
      send_check("data_bit3", c, 8'd3, 1'b1, 1'b0);
      c = '0; c[0] = 1'b1;
      send_check("par_bit0", c, 8'd0, 1'b1, 1'b0);
      c = '0; c[136] = 1'b1;
      send_check("bit136", c, 8'd136, 1'b1, 1'b0);
      c = '0; c[3] = 1'b1; c[5] = 1'b1;
      send_check("dbl_3_5", c, 8'd6, 1'b0, 1'b1);
      c = '0; c[0] = 1'b1; c[127] = 1'b1; c[128] = 1'b1;
      send_check("tri_0_127_128", c, 8'd255, 1'b0, 1'b1);

      // Backpressure: 5 stalled cycles while 4 words are offered
      for (int i = 0; i < 4; i++) w[i] = rand_code();
      out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 5; i++) begin
         in_code  = w[idx];
         in_valid = 1'b1;
         step();
         if (last_acc) idx++;
      end
      chk("bp_accepted", idx, 2);
      chk("bp_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && idx < 4; i++) begin
         in_code  = w[idx];
         in_valid = 1'b1;
         step();
         if (last_acc) idx++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", idx, 4);
      drain("bp_drain");

      // Randomized traffic with random backpressure and occasional counter clears
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         cnt_clr   = ($urandom % 40) == 0;
         in_code   = rand_code();
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      drain("rand_drain");

      // Saturation: 5 corrected words on a 2-bit counter
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c = encode({$urandom, $urandom, $urandom, $urandom});
         c[$urandom_range(136, 0)] ^= 1'b1;
         send(c);
      end
      drain("sat_drain");
      chk("sec_saturated", sec_cnt, 3);

      // Clear coincident with a ded delivery wins
      c = '0; c[3] = 1'b1; c[5] = 1'b1;
      send(c);
      drain("ded1_drain");
      chk("ded_one", ded_cnt, 1);
      out_ready = 1'b0;
      send(c);
      wait_out("ded2_timeout");
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      step();
      cnt_clr   = 1'b0;
      chk("ded_clr_priority", ded_cnt, 0);
      chk("sec_clr_priority", sec_cnt, 0);

      // Reset asserted mid-stream discards words in flight
      for (int i = 0; i < 3; i++) begin
         c = encode({$urandom, $urandom, $urandom, $urandom});
         c[$urandom_range(136, 0)] ^= 1'b1;
         in_code  = c;
         in_valid = 1'b1;
         step();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_out_data", out_data, 128'd0);
      chk("midrst_out_flags", {out_sec, out_ded}, 2'b00);
      chk("midrst_out_syn", out_syndrome, 8'd0);
      chk("midrst_sec_cnt", sec_cnt, 0);
      chk("midrst_ded_cnt", ded_cnt, 0);
      exp_q.delete();
      m_sec    = 0;
      m_ded    = 0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("postrst_in_ready", in_ready, 1'b1);
      repeat (5) step();

      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
